// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, FSM state type and arithmetic helpers for the
// time-multiplexed 32-tap symmetric FIR sequencer (fir_mac_sched).
//   NTAP/NPAIR : window length and number of symmetric tap pairs
//   DW/CW/AW   : sample, coefficient and accumulator widths (all signed)
//   SHIFT      : right shift applied to the accumulator to form the result
package fir_pkg;

    localparam int NTAP  = 32;
    localparam int NPAIR = NTAP / 2;
    localparam int DW    = 16;
    localparam int CW    = 20;
    localparam int AW    = 40;
    localparam int SHIFT = 16;

    localparam int KW = 4;          // pair index width
    localparam int XW = 5;          // window index width
    localparam int FW = 6;          // fill counter width, counts 0..NTAP
    localparam int SW = DW + 1;     // pre-adder (pair sum) width
    localparam int PW = SW + CW;    // product width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Pre-adder: both samples are sign-extended by one bit so the sum cannot overflow.
    function automatic logic signed [SW-1:0] pair_sum(input logic [DW-1:0] a,
                                                      input logic [DW-1:0] b);
        return $signed({a[DW-1], a}) + $signed({b[DW-1], b});
    endfunction

    // Arithmetic shift plus the accumulator sign bit; the result wraps into DW bits.
    function automatic logic [DW-1:0] round_acc(input logic [AW-1:0] acc);
        logic signed [AW-1:0] sh;
        logic [AW-1:0]        r;
        sh = $signed(acc) >>> SHIFT;
        r  = sh + {{(AW-1){1'b0}}, acc[AW-1]};
        return r[DW-1:0];
    endfunction

endpackage

// File: rtl/fir_tap_buf.sv
// fir_tap_buf: 32-entry sample window with fill counter and symmetric pair read.
//   clk, rst_n : clock, synchronous active-low reset
//   shift      : push din into x[31], older samples move toward x[0]
//   clear      : zero the window and the fill counter (wins over shift)
//   din        : sample to push
//   k          : pair index; xa = x[k], xb = x[31-k] (combinational)
//   fill       : number of samples held, saturates at NTAP
module fir_tap_buf
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          shift,
    input  logic          clear,
    input  logic [DW-1:0] din,
    input  logic [KW-1:0] k,
    output logic [DW-1:0] xa,
    output logic [DW-1:0] xb,
    output logic [FW-1:0] fill
);

    logic [DW-1:0] win_r [NTAP];
    logic [FW-1:0] fill_r;
    logic [XW-1:0] kb_s;

    // Window shift/clear and saturating fill count.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < NTAP; i++) begin
                win_r[i] <= '0;
            end
            fill_r <= '0;
        end else if (shift) begin
            for (int i = 0; i < NTAP - 1; i++) begin
                win_r[i] <= win_r[i+1];
            end
            win_r[NTAP-1] <= din;
            if (fill_r != FW'(NTAP)) begin
                fill_r <= fill_r + 6'd1;
            end
        end
    end

    // Mirror index for the far tap of pair k.
    always_comb begin
        kb_s = 5'd31 - {1'b0, k};
        xa   = win_r[k];
        xb   = win_r[kb_s];
    end

    assign fill = fill_r;

endmodule

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: shares one pre-add/multiply/accumulate slice across the 16
// symmetric tap pairs of a 32-tap FIR, one pair per clock.
//   clk, rst_n            : clock, synchronous active-low reset
//   data_valid/data/data_ready : sample input handshake (accept = valid && ready)
//   flush                 : clear window and fill count, honoured only in IDLE
//   coef_wr/coef_addr/coef_data : coefficient write, committed only in IDLE
//   coef_err              : one-cycle pulse when a write was dropped (busy)
//   fir_valid/fir_d       : one-cycle pulse with new result; fir_d held otherwise
// One sample takes 18 clocks: accept, 16 MAC cycles, one DONE cycle.
module fir_mac_sched
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          data_valid,
    input  logic [DW-1:0] data,
    output logic          data_ready,
    input  logic          flush,
    input  logic          coef_wr,
    input  logic [KW-1:0] coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          coef_err,
    output logic          fir_valid,
    output logic [DW-1:0] fir_d
);

    state_t                state_r;
    logic [KW-1:0]         k_r;
    logic [AW-1:0]         acc_r;
    logic signed [CW-1:0]  coef_r [NPAIR];
    logic                  fir_valid_r;
    logic [DW-1:0]         fir_d_r;
    logic                  coef_err_r;

    logic                  idle_s;
    logic                  accept_s;
    logic                  clear_s;
    logic [DW-1:0]         xa_s;
    logic [DW-1:0]         xb_s;
    logic [FW-1:0]         fill_s;
    logic signed [SW-1:0]  psum_s;
    logic signed [PW-1:0]  prod_s;
    logic [AW-1:0]         acc_add_s;
    logic [DW-1:0]         round_s;

    assign idle_s   = (state_r == IDLE);
    assign accept_s = idle_s && data_valid && !flush;
    assign clear_s  = idle_s && flush;
    // Gated by rst_n so no sample is taken while reset is held.
    assign data_ready = rst_n && idle_s && !flush;

    fir_tap_buf u_tap_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (accept_s),
        .clear (clear_s),
        .din   (data),
        .k     (k_r),
        .xa    (xa_s),
        .xb    (xb_s),
        .fill  (fill_s)
    );

    // Shared MAC datapath and output rounding.
    always_comb begin
        psum_s    = pair_sum(xa_s, xb_s);
        prod_s    = psum_s * coef_r[k_r];
        acc_add_s = acc_r + {{(AW-PW){prod_s[PW-1]}}, prod_s};
        round_s   = round_acc(acc_r);
    end

    // Sequencer FSM, coefficient table and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            k_r         <= 4'd0;
            acc_r       <= '0;
            fir_valid_r <= 1'b0;
            fir_d_r     <= '0;
            coef_err_r  <= 1'b0;
            for (int i = 0; i < NPAIR; i++) begin
                coef_r[i] <= '0;
            end
        end else begin
            fir_valid_r <= 1'b0;
            // A write in the accept cycle lands before the first MAC cycle reads it.
            coef_err_r  <= coef_wr && !idle_s;
            if (coef_wr && idle_s) begin
                coef_r[coef_addr] <= coef_data;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        acc_r   <= '0;
                        k_r     <= 4'd0;
                        state_r <= MAC;
                    end
                end
                MAC: begin
                    acc_r <= acc_add_s;
                    k_r   <= k_r + 4'd1;
                    if (k_r == 4'(NPAIR - 1)) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    // Results are only published once the window holds real samples.
                    if (fill_s == FW'(NTAP)) begin
                        fir_d_r     <= round_s;
                        fir_valid_r <= 1'b1;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign fir_valid = fir_valid_r;
    assign fir_d     = fir_d_r;
    assign coef_err  = coef_err_r;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed self-checking bench for fir_mac_sched.
module tb_fir_mac_sched;

    logic        clk;
    logic        rst_n;
    logic        data_valid;
    logic [15:0] data;
    logic        data_ready;
    logic        flush;
    logic        coef_wr;
    logic [3:0]  coef_addr;
    logic [19:0] coef_data;
    logic        coef_err;
    logic        fir_valid;
    logic [15:0] fir_d;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          n0    = 0;
    int          np    = 0;
    int          hist[$];
    logic [15:0] pq[$];
    int          pt[$];

    fir_mac_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_valid (data_valid),
        .data       (data),
        .data_ready (data_ready),
        .flush      (flush),
        .coef_wr    (coef_wr),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_err   (coef_err),
        .fir_valid  (fir_valid),
        .fir_d      (fir_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Result pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (fir_valid) begin
            pq.push_back(fir_d);
            pt.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic reset_hist();
        hist.delete();
        for (int i = 0; i < 32; i++) hist.push_back(0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!data_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!data_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [19:0] v);
        wait_ready();
        coef_wr = 1'b1; coef_addr = a; coef_data = v;
        @(posedge clk); #1;
        coef_wr = 1'b0;
    endtask

    task automatic send_only(input logic [15:0] v);
        wait_ready();
        data_valid = 1'b1; data = v;
        hist.push_back(int'($signed(v)));
        n0 = pq.size();
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic finish_wait();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!data_ready && n < 40);
        if (!data_ready) chk("done_timeout", 32'd0, 32'd1);
        np = pq.size() - n0;
    endtask

    task automatic send(input logic [15:0] v);
        send_only(v);
        finish_wait();
    endtask

    initial begin
        int          nsum;
        int          base;
        int          at[20];
        logic [15:0] expq[$];
        logic [15:0] e16;

        rst_n = 1'b0; data_valid = 1'b1; data = 16'h1234; flush = 1'b0;
        coef_wr = 1'b0; coef_addr = 4'd0; coef_data = 20'd0;
        reset_hist();

        // 1: reset with data_valid held high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready_low", {31'd0, data_ready}, 32'd0);
        end
        rst_n = 1'b1; data_valid = 1'b0;
        #1;
        chk("rst_ready_high", {31'd0, data_ready}, 32'd1);
        chk("rst_fir_d", {16'd0, fir_d}, 32'd0);
        chk("rst_fir_valid", {31'd0, fir_valid}, 32'd0);
        chk("rst_coef_err", {31'd0, coef_err}, 32'd0);

        // 2: pass-through via C15
        write_coef(4'd15, 20'd65536);
        for (int i = 0; i < 31; i++) begin
            send(16'(i));
            chk("t2_no_pulse", np, 32'd0);
        end
        send(16'd31);
        chk("t2_pulse32", np, 32'd1);
        chk("t2_fir32", {16'd0, fir_d}, 32'd31);
        send(16'd100);
        chk("t2_pulse33", np, 32'd1);
        chk("t2_fir33", {16'd0, fir_d}, 32'd33);

        // 3: negative rounding, acc = -2 gives 0
        write_coef(4'd15, 20'd0);
        write_coef(4'd0, 20'hFFFFF);
        for (int i = 0; i < 32; i++) send(16'd1);
        chk("t3_pulse", np, 32'd1);
        chk("t3_fir_neg", {16'd0, fir_d}, 32'd0);

        // 4: write during MAC is dropped; IDLE write (same cycle as accept) is used
        write_coef(4'd0, 20'd0);
        write_coef(4'd15, 20'd65536);
        chk("t4_err_idle", {31'd0, coef_err}, 32'd0);
        send_only(16'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        coef_wr = 1'b1; coef_addr = 4'd15; coef_data = 20'd0;
        @(posedge clk); #1;
        coef_wr = 1'b0;
        @(negedge clk);
        chk("t4_err_pulse", {31'd0, coef_err}, 32'd1);
        @(negedge clk);
        chk("t4_err_clear", {31'd0, coef_err}, 32'd0);
        finish_wait();
        chk("t4_busy_pulse", np, 32'd1);
        chk("t4_busy_fir", {16'd0, fir_d}, 32'd2);
        wait_ready();
        coef_wr = 1'b1; coef_addr = 4'd15; coef_data = 20'd131072;
        data_valid = 1'b1; data = 16'd7;
        hist.push_back(7);
        n0 = pq.size();
        @(posedge clk); #1;
        coef_wr = 1'b0; data_valid = 1'b0;
        finish_wait();
        chk("t4_same_cyc_err", {31'd0, coef_err}, 32'd0);
        chk("t4_same_cyc_fir", {16'd0, fir_d}, 32'd4);

        // 5: data_valid held continuously
        write_coef(4'd15, 20'd65536);
        base = pq.size();
        data_valid = 1'b1;
        for (int j = 0; j < 20; j++) begin
            int n;
            data = 16'(10 + j);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!data_ready && n < 40);
            if (!data_ready) chk("t5_ready_timeout", 32'd0, 32'd1);
            hist.push_back(10 + j);
            e16 = 16'(hist[hist.size()-16] + hist[hist.size()-17]);
            expq.push_back(e16);
            @(posedge clk); #1;
            at[j] = cyc;
        end
        data_valid = 1'b0;
        n0 = pq.size();
        finish_wait();
        for (int j = 1; j < 20; j++) chk("t5_accept_gap", at[j] - at[j-1], 32'd18);
        chk("t5_pulse_cnt", pq.size() - base, 32'd20);
        for (int j = 0; j < 20 && base + j < pq.size(); j++) begin
            chk("t5_fir", {16'd0, pq[base+j]}, {16'd0, expq[j]});
            if (j > 0) chk("t5_pulse_gap", pt[base+j] - pt[base+j-1], 32'd18);
        end

        // 6: flush, with data_valid in the same cycle
        wait_ready();
        e16 = fir_d;
        flush = 1'b1; data_valid = 1'b1; data = 16'd77;
        #1;
        chk("t6_ready_flush", {31'd0, data_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; data_valid = 1'b0;
        reset_hist();
        chk("t6_fir_kept", {16'd0, fir_d}, {16'd0, e16});
        nsum = 0;
        for (int i = 1; i < 32; i++) begin
            send(16'(i));
            nsum += np;
        end
        chk("t6_no_pulse31", nsum, 32'd0);
        send(16'd32);
        chk("t6_pulse32", np, 32'd1);
        chk("t6_fir32", {16'd0, fir_d}, 32'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
